// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, ALU operation classes and the EX-stage
// control bundle carried through the ID/EX register.
package rv32i_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU operation classes
    localparam int         ULA_OP_W     = 2;
    localparam logic [1:0] ULA_OP_ADD   = 2'b00;  // add / address generation
    localparam logic [1:0] ULA_OP_FUNCT = 2'b01;  // decoded from funct3/funct7

    // Control bundle handed from the decoder to EX/MEM/WB
    typedef struct packed {
        logic                mem_rd;
        logic                mem_wr;
        logic                reg_wr;
        logic                mux_reg_wr;
        logic                jal_reg;
        logic                jump;
        logic                mux_ula;
        logic                branch;
        logic [ULA_OP_W-1:0] ula_op;
    } ex_ctrl_t;

    localparam int EX_CTRL_W = $bits(ex_ctrl_t);

    // Clear every control bit that could change architectural state
    // (memory, register file, PC redirect); steering bits are kept.
    function automatic ex_ctrl_t kill_side_effects(input ex_ctrl_t c);
        ex_ctrl_t k;
        k         = c;
        k.mem_rd  = 1'b0;
        k.mem_wr  = 1'b0;
        k.reg_wr  = 1'b0;
        k.branch  = 1'b0;
        k.jump    = 1'b0;
        k.jal_reg = 1'b0;
        return k;
    endfunction

endpackage

// File: rtl/id_ex_reg_hazard_unit.sv
// Load-use hazard detection for the ID/EX boundary (purely combinational).
module hazard_unit
    import rv32i_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_rd,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              flush,
    input  logic              ext_stall,
    output logic              load_use,
    output logic              hazard_stall
);

    // A load in EX whose destination feeds the ID instruction; x0 never hazards.
    // Flush or a downstream hold already decides the edge, so no front-end stall then.
    always_comb begin
        load_use     = ex_valid && ex_mem_rd && (ex_rd != '0) && id_valid &&
                       ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        hazard_stall = load_use && !flush && !ext_stall;
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register of the RV32I pipeline: register bank plus the
// flush / hold / load-use-bubble / capture priority mux.
// Optional feature macro: ID_EX_PERF_CNT_EN adds perf_bubbles / perf_flushes counters.
module id_ex_reg
    import rv32i_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_mem_rd,
    input  logic              id_mem_wr,
    input  logic              id_reg_wr,
    input  logic              id_mux_reg_wr,
    input  logic              id_jalReg,
    input  logic              id_jump,
    input  logic              id_mux_ula,
    input  logic              id_branch,
    input  logic [1:0]        id_ula_op,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7b5,
    input  logic              ext_stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic              ex_reg_wr,
    output logic              ex_mux_reg_wr,
    output logic              ex_jalReg,
    output logic              ex_jump,
    output logic              ex_mux_ula,
    output logic              ex_branch,
    output logic [1:0]        ex_ula_op,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7b5,
    output logic              hazard_stall
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       perf_bubbles,
    output logic [31:0]       perf_flushes
`endif
);

    ex_ctrl_t id_ctrl;
    ex_ctrl_t capt_ctrl;
    ex_ctrl_t ex_ctrl;
    logic     load_use;

    hazard_unit #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .ex_valid     (ex_valid),
        .ex_mem_rd    (ex_ctrl.mem_rd),
        .ex_rd        (ex_rd),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .flush        (flush),
        .ext_stall    (ext_stall),
        .load_use     (load_use),
        .hazard_stall (hazard_stall)
    );

    // Bundle decoder controls; an invalid slot may not touch memory, regs or PC.
    always_comb begin
        id_ctrl.mem_rd     = id_mem_rd;
        id_ctrl.mem_wr     = id_mem_wr;
        id_ctrl.reg_wr     = id_reg_wr;
        id_ctrl.mux_reg_wr = id_mux_reg_wr;
        id_ctrl.jal_reg    = id_jalReg;
        id_ctrl.jump       = id_jump;
        id_ctrl.mux_ula    = id_mux_ula;
        id_ctrl.branch     = id_branch;
        id_ctrl.ula_op     = id_ula_op;
        capt_ctrl          = id_valid ? id_ctrl : kill_side_effects(id_ctrl);
    end

    // Register bank: flush > ext_stall (hold) > load-use bubble > capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush || (!ext_stall && load_use)) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
        end else if (!ext_stall) begin
            ex_valid    <= id_valid;
            ex_ctrl     <= capt_ctrl;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct3   <= id_funct3;
            ex_funct7b5 <= id_funct7b5;
        end
    end

    assign ex_mem_rd     = ex_ctrl.mem_rd;
    assign ex_mem_wr     = ex_ctrl.mem_wr;
    assign ex_reg_wr     = ex_ctrl.reg_wr;
    assign ex_mux_reg_wr = ex_ctrl.mux_reg_wr;
    assign ex_jalReg     = ex_ctrl.jal_reg;
    assign ex_jump       = ex_ctrl.jump;
    assign ex_mux_ula    = ex_ctrl.mux_ula;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_ula_op     = ex_ctrl.ula_op;

`ifdef ID_EX_PERF_CNT_EN
    // Event counters: every flush edge counts; a load-use bubble counts only
    // when it actually lands (not masked by flush or a downstream hold).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bubbles <= '0;
            perf_flushes <= '0;
        end else if (flush) begin
            perf_flushes <= perf_flushes + 32'd1;
        end else if (!ext_stall && load_use) begin
            perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed table, hand-written reset
// sequence and randomized traffic against a rule-level reference model.
module tb_id_ex_reg;

    typedef struct packed {
        logic        valid;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
        logic        mux_reg_wr;
        logic        jal_reg;
        logic        jump;
        logic        mux_ula;
        logic        branch;
        logic [1:0]  ula_op;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
    } fields_t;

    typedef struct {
        logic        v;
        logic        mrd;
        logic        rw;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        st;
        logic        fl;
        logic        e_hs;
        logic        e_v;
        logic        e_mrd;
        logic        e_rw;
        logic [31:0] e_pc;
        logic [4:0]  e_rd;
    } vec_t;

    logic    clk = 1'b0;
    logic    rst;
    logic    ext_stall;
    logic    flush;
    fields_t id;
    fields_t ex_act;
    logic    hazard_stall;
    logic    ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr;
    logic    ex_jalReg, ex_jump, ex_mux_ula, ex_branch, ex_funct7b5;
    logic [1:0]  ex_ula_op;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_bubbles, perf_flushes;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    fields_t     exp_ex;
    logic [31:0] exp_bubbles;
    logic [31:0] exp_flushes;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id.valid),
        .id_mem_rd     (id.mem_rd),
        .id_mem_wr     (id.mem_wr),
        .id_reg_wr     (id.reg_wr),
        .id_mux_reg_wr (id.mux_reg_wr),
        .id_jalReg     (id.jal_reg),
        .id_jump       (id.jump),
        .id_mux_ula    (id.mux_ula),
        .id_branch     (id.branch),
        .id_ula_op     (id.ula_op),
        .id_pc         (id.pc),
        .id_rs1_data   (id.rs1_data),
        .id_rs2_data   (id.rs2_data),
        .id_imm        (id.imm),
        .id_rs1        (id.rs1),
        .id_rs2        (id.rs2),
        .id_rd         (id.rd),
        .id_funct3     (id.funct3),
        .id_funct7b5   (id.funct7b5),
        .ext_stall     (ext_stall),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_mem_rd     (ex_mem_rd),
        .ex_mem_wr     (ex_mem_wr),
        .ex_reg_wr     (ex_reg_wr),
        .ex_mux_reg_wr (ex_mux_reg_wr),
        .ex_jalReg     (ex_jalReg),
        .ex_jump       (ex_jump),
        .ex_mux_ula    (ex_mux_ula),
        .ex_branch     (ex_branch),
        .ex_ula_op     (ex_ula_op),
        .ex_pc         (ex_pc),
        .ex_rs1_data   (ex_rs1_data),
        .ex_rs2_data   (ex_rs2_data),
        .ex_imm        (ex_imm),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_funct3     (ex_funct3),
        .ex_funct7b5   (ex_funct7b5),
        .hazard_stall  (hazard_stall)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .perf_bubbles  (perf_bubbles),
        .perf_flushes  (perf_flushes)
`endif
    );

    assign ex_act = {ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr,
                     ex_jalReg, ex_jump, ex_mux_ula, ex_branch, ex_ula_op,
                     ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                     ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5};

    task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic check_f(input string name, input fields_t act, input fields_t expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, expv);
        end
    endtask

    // One clock: drive at negedge, check the combinational stall, advance the
    // model by the priority rules, then check the registered result.
    task automatic cycle(input fields_t f, input logic st, input logic fl, input string tag);
        logic lu;
        logic exp_hs;
        id        = f;
        ext_stall = st;
        flush     = fl;
        #1;
        lu = exp_ex.valid && exp_ex.mem_rd && (exp_ex.rd != 5'd0) && f.valid &&
             ((exp_ex.rd == f.rs1) || (exp_ex.rd == f.rs2));
        exp_hs = lu && !fl && !st;
        check_v({tag, "_hazard_stall"}, 32'(hazard_stall), 32'(exp_hs));
        if (fl) begin
            exp_ex = '0;
            exp_flushes = exp_flushes + 32'd1;
        end else if (st) begin
            exp_ex = exp_ex;
        end else if (lu) begin
            exp_ex = '0;
            exp_bubbles = exp_bubbles + 32'd1;
        end else begin
            exp_ex = f;
            if (!f.valid) begin
                exp_ex.mem_rd  = 1'b0;
                exp_ex.mem_wr  = 1'b0;
                exp_ex.reg_wr  = 1'b0;
                exp_ex.branch  = 1'b0;
                exp_ex.jump    = 1'b0;
                exp_ex.jal_reg = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_f({tag, "_ex_fields"}, ex_act, exp_ex);
`ifdef ID_EX_PERF_CNT_EN
        check_v({tag, "_perf_bubbles"}, perf_bubbles, exp_bubbles);
        check_v({tag, "_perf_flushes"}, perf_flushes, exp_flushes);
`endif
    endtask

    function automatic fields_t rand_fields();
        fields_t f;
        f.valid      = ($urandom_range(0, 9) < 8);
        f.mem_rd     = $urandom_range(0, 1);
        f.mem_wr     = $urandom_range(0, 1);
        f.reg_wr     = $urandom_range(0, 1);
        f.mux_reg_wr = $urandom_range(0, 1);
        f.jal_reg    = $urandom_range(0, 1);
        f.jump       = $urandom_range(0, 1);
        f.mux_ula    = $urandom_range(0, 1);
        f.branch     = $urandom_range(0, 1);
        f.ula_op     = 2'($urandom_range(0, 3));
        f.pc         = $urandom;
        f.rs1_data   = $urandom;
        f.rs2_data   = $urandom;
        f.imm        = $urandom;
        f.rs1        = 5'($urandom_range(0, 3));
        f.rs2        = 5'($urandom_range(0, 3));
        f.rd         = 5'($urandom_range(0, 3));
        f.funct3     = 3'($urandom_range(0, 7));
        f.funct7b5   = $urandom_range(0, 1);
        return f;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    tbl[14];
        fields_t f;

        //            v mrd rw pc        rd rs1 rs2 imm st fl | hs v mrd rw pc        rd
        tbl[0]  = '{1, 0, 1, 32'h10, 1,  0,  0,  5, 0, 0,   0, 1, 0, 1, 32'h10, 1};   // addi x1,x0,5
        tbl[1]  = '{1, 1, 1, 32'h14, 5,  1,  0,  0, 0, 0,   0, 1, 1, 1, 32'h14, 5};   // lw x5,0(x1)
        tbl[2]  = '{1, 0, 1, 32'h18, 6,  5,  1,  0, 0, 0,   1, 0, 0, 0, 32'h00, 0};   // add x6,x5,x1 -> bubble
        tbl[3]  = '{1, 0, 1, 32'h18, 6,  5,  1,  0, 0, 0,   0, 1, 0, 1, 32'h18, 6};   // add re-presented
        tbl[4]  = '{1, 1, 1, 32'h1c, 0,  1,  0,  0, 0, 0,   0, 1, 1, 1, 32'h1c, 0};   // lw x0
        tbl[5]  = '{1, 0, 1, 32'h20, 7,  0,  0,  0, 0, 0,   0, 1, 0, 1, 32'h20, 7};   // reads x0: no hazard
        tbl[6]  = '{1, 1, 1, 32'h24, 8,  7,  0,  0, 0, 0,   0, 1, 1, 1, 32'h24, 8};   // lw x8
        tbl[7]  = '{1, 0, 1, 32'h28, 9,  8,  8,  0, 0, 1,   0, 0, 0, 0, 32'h00, 0};   // flush + load_use
        tbl[8]  = '{0, 1, 1, 32'h2c, 9,  0,  0,  0, 0, 0,   0, 0, 0, 0, 32'h2c, 9};   // invalid slot
        tbl[9]  = '{1, 1, 1, 32'h30, 10, 0,  0,  0, 0, 0,   0, 1, 1, 1, 32'h30, 10};  // lw x10
        tbl[10] = '{1, 0, 1, 32'h34, 11, 10, 0,  0, 1, 0,   0, 1, 1, 1, 32'h30, 10};  // ext_stall hold
        tbl[11] = '{1, 0, 1, 32'h38, 11, 10, 0,  0, 1, 0,   0, 1, 1, 1, 32'h30, 10};  // ext_stall hold
        tbl[12] = '{1, 0, 1, 32'h3c, 12, 0,  0,  0, 1, 0,   0, 1, 1, 1, 32'h30, 10};  // ext_stall hold
        tbl[13] = '{1, 0, 1, 32'h40, 13, 3,  4,  0, 0, 0,   0, 1, 0, 1, 32'h40, 13};  // resume

        // Reset state, checked before any clock edge
        rst         = 1'b1;
        ext_stall   = 1'b0;
        flush       = 1'b0;
        id          = rand_fields();
        exp_ex      = '0;
        exp_bubbles = '0;
        exp_flushes = '0;
        #1;
        check_f("reset_ex_fields", ex_act, '0);
        check_v("reset_hazard_stall", 32'(hazard_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            f          = '0;
            f.valid    = tbl[i].v;
            f.mem_rd   = tbl[i].mrd;
            f.reg_wr   = tbl[i].rw;
            f.mux_ula  = 1'b1;
            f.ula_op   = tbl[i].mrd ? 2'b00 : 2'b01;
            f.funct3   = tbl[i].mrd ? 3'b010 : 3'b000;
            f.pc       = tbl[i].pc;
            f.rd       = tbl[i].rd;
            f.rs1      = tbl[i].rs1;
            f.rs2      = tbl[i].rs2;
            f.imm      = tbl[i].imm;
            f.rs1_data = $urandom;
            f.rs2_data = $urandom;
            id        = f;
            ext_stall = tbl[i].st;
            flush     = tbl[i].fl;
            #1;
            check_v($sformatf("tbl%0d_hs", i), 32'(hazard_stall), 32'(tbl[i].e_hs));
            cycle(f, tbl[i].st, tbl[i].fl, $sformatf("tbl%0d", i));
            check_v($sformatf("tbl%0d_valid", i),  32'(ex_valid),  32'(tbl[i].e_v));
            check_v($sformatf("tbl%0d_mem_rd", i), 32'(ex_mem_rd), 32'(tbl[i].e_mrd));
            check_v($sformatf("tbl%0d_reg_wr", i), 32'(ex_reg_wr), 32'(tbl[i].e_rw));
            check_v($sformatf("tbl%0d_pc", i),     ex_pc,          tbl[i].e_pc);
            check_v($sformatf("tbl%0d_rd", i),     32'(ex_rd),     32'(tbl[i].e_rd));
            if (i == 0) check_v("tbl0_imm", ex_imm, 32'd5);
        end
`ifdef ID_EX_PERF_CNT_EN
        check_v("tbl_perf_bubbles", perf_bubbles, 32'd1);
        check_v("tbl_perf_flushes", perf_flushes, 32'd1);
`endif

        // Reset asserted mid-stall, between clock edges
        f        = '0;
        f.valid  = 1'b1;
        f.mem_rd = 1'b1;
        f.reg_wr = 1'b1;
        f.rd     = 5'd14;
        f.pc     = 32'h44;
        cycle(f, 1'b0, 1'b0, "rst_setup");
        f        = '0;
        f.valid  = 1'b1;
        f.reg_wr = 1'b1;
        f.rs1    = 5'd14;
        f.rd     = 5'd15;
        f.pc     = 32'h48;
        id       = f;
        #1;
        check_v("midstall_hs_before_rst", 32'(hazard_stall), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_f("midstall_rst_ex_fields", ex_act, '0);
        check_v("midstall_rst_hs", 32'(hazard_stall), 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        check_v("midstall_rst_perf_bubbles", perf_bubbles, 32'd0);
        check_v("midstall_rst_perf_flushes", perf_flushes, 32'd0);
`endif
        @(negedge clk);
        check_f("rst_held_ex_fields", ex_act, '0);
        rst         = 1'b0;
        exp_ex      = '0;
        exp_bubbles = '0;
        exp_flushes = '0;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(rand_fields(),
                  ($urandom_range(0, 9) < 2),
                  ($urandom_range(0, 9) < 1),
                  $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
